mdu_seq: RTL
============

# mdu_seq

Parametrised sequential multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage. It replaces the fixed 32-bit radix-2 divider with a unit that is configurable in width, divider radix and multiply latency, and adds an explicit accept/busy handshake. It also adds HI/LO ownership (MTHI/MTLO), flush abort and defined divide-by-zero results. The execute stage holds the issuing instruction while `busy` is high.

## Interface
Parameters:
- `DATA_W`, 32, operand width; HI and LO are each `DATA_W` bits; must be even and at least 8.
- `DIV_RADIX_BITS`, 1, quotient bits retired per divide cycle (1 or 2); `DATA_W` must be divisible by it.
- `MUL_LAT`, 2, multiply cycles from accept to HI/LO update (1..4).

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  exception/ERET flush; aborts any operation in flight.
- `kill`  in  1  an exception is pending in EXE, MEM or WB; blocks acceptance.
- `op_valid`  in  1  operation request.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6 and 7 are ignored.
- `src1`  in  DATA_W  rs value (dividend, or the MTHI/MTLO source).
- `src2`  in  DATA_W  rt value (divisor).
- `op_ready`  out  1  the unit is idle and can accept.
- `busy`  out  1  a multiply or divide is in flight (this is the stall to EXE).
- `hi_q`  out  DATA_W  architectural HI.
- `lo_q`  out  DATA_W  architectural LO.

## Operation
- Accept: `op_valid & op_ready & ~kill & ~flush` at a rising edge, with a valid `op`.
- States: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on an accepted MULT/MULTU. IDLE -> DIV on an accepted DIV/DIVU.
  - MTHI/MTLO write `hi_q`/`lo_q` at the accept edge and stay in IDLE.
  - MUL: a countdown starts at `MUL_LAT-1`. When it reaches 0, `{hi,lo}` takes the 2·`DATA_W` product and the state returns to IDLE.
  - DIV: operands are latched as magnitudes, with the sign of quotient and remainder latched alongside. One `mdu_div_step` chain runs per cycle for `DATA_W/DIV_RADIX_BITS` cycles, then the state moves to FIX.
  - FIX: sign correction is applied, LO takes the quotient and HI the remainder, and the state returns to IDLE.
- Signed divide:
  - The quotient is negative when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - MIN / -1 gives LO = MIN and HI = 0.
- Divide by zero runs full latency. Result: LO = all ones, HI = `src1` unchanged. This is the same for DIV and DIVU.
- `flush`:
  - At the next edge the state goes to IDLE, the result is discarded, and HI/LO are untouched.
  - Flush wins over a completion at the same edge.
- `kill` has no effect once an operation has been accepted.
- `op_ready` = (state == IDLE). `busy` = (state != IDLE). Both are combinational from the state.

## Timing
- Reset (asynchronous, active-low): state IDLE, `hi_q` = `lo_q` = 0, `busy` = 0, `op_ready` = 1, counters = 0.
- Accept edge is T0.
  - MUL: new HI/LO is visible after edge T0+`MUL_LAT`. `busy` is high for `MUL_LAT` cycles.
  - DIV: new HI/LO is visible after edge T0+`DATA_W/DIV_RADIX_BITS`+1. With `DATA_W`=32 and radix 1 that is 33 busy cycles; with radix 2 it is 17.
  - MTHI/MTLO: visible after T0, no busy.
- Back-to-back: a new op can be accepted in the first IDLE cycle after completion, which means zero bubbles.
- HI/LO reads are never forwarded. EXE must not read HI/LO while `busy`.

## Structure
- `mdu_pkg`: op encoding localparams, the state enum, and the zero-divisor result constants.
- Sub-module `mdu_div_step`: combinational restoring-division step (partial remainder, divisor, dividend bit in; new remainder and quotient bit out), instanced `DIV_RADIX_BITS` times in a chain.
- The product is computed from the latched operands. It is a multicycle path covered by `MUL_LAT`.

## Test plan
- DIV 100 / -7 (0xFFFFFFF9) -> LO = 0xFFFFFFF2, HI = 2. `busy` is high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF with `MUL_LAT`=2 -> HI = 0xFFFFFFFE, LO = 0x00000001 after T0+2. MULT on the same operands -> HI = 0, LO = 1.
- DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 5. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- MTHI 0x1234 while a DIV is in flight is refused (`op_ready`=0). After the DIV completes, MTHI is accepted and HI = 0x1234.
- DIV started, then `flush` at cycle 10 -> HI/LO keep their prior values and `op_ready` = 1 the next cycle. `flush` coinciding with the FIX edge -> no update.
- `resetn` asserted mid-divide -> outputs are immediately at their reset values. `kill`=1 with `op_valid` -> nothing is accepted. `DIV_RADIX_BITS`=2 -> 17-cycle latency with results matching radix 1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// op encodings, FSM state type and divide-by-zero result constants.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    // x / 0: LO is filled with this bit, HI returns the dividend as given
    localparam logic DZ_LO_BIT     = 1'b1;
    localparam logic DZ_HI_IS_SRC1 = 1'b1;

    function automatic logic op_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if non-negative.
// Ports: rem_i/dvs_i/bit_i in; rem_o (new remainder), q_o (quotient bit) out.
module mdu_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] dvs_i,
    input  logic         bit_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] trial;
    logic [W:0] diff;

    assign trial = {rem_i, bit_i};
    assign diff  = trial - {1'b0, dvs_i};
    assign q_o   = ~diff[W];
    // remainder stays below the divisor, so W bits always suffice
    assign rem_o = q_o ? diff[W-1:0] : trial[W-1:0];

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
// Ports: clk, resetn, flush, kill, op_valid, op, src1, src2 in;
// op_ready, busy, hi_q, lo_q out.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DIV_RADIX_BITS = 1,
    parameter int MUL_LAT        = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              kill,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              op_ready,
    output logic              busy,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q
);

    localparam int N  = DATA_W / DIV_RADIX_BITS;
    localparam int CW = $clog2(DATA_W + 1);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] hi_d, lo_d;
    logic sgn_q, sgn_d;
    logic negq_q, negq_d;
    logic negr_q, negr_d;

    logic              sd;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W-1:0] rem_nxt;
    logic [DIV_RADIX_BITS-1:0] qbits;
    logic [2*DATA_W-1:0] ax, bx, prod;

    assign op_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);

    assign sd    = op_signed(op);
    assign a_mag = (sd & src1[DATA_W-1]) ? -src1 : src1;
    assign b_mag = (sd & src2[DATA_W-1]) ? -src2 : src2;

    // product of latched operands; settles within MUL_LAT cycles
    assign ax = sgn_q ? {{DATA_W{a_q[DATA_W-1]}}, a_q}
                      : {{DATA_W{1'b0}}, a_q};
    assign bx = sgn_q ? {{DATA_W{b_q[DATA_W-1]}}, b_q}
                      : {{DATA_W{1'b0}}, b_q};
    assign prod = ax * bx;

    // quo_q doubles as the dividend shifter: its MSBs feed the chain,
    // quotient bits enter at the bottom
    for (genvar j = 0; j < DIV_RADIX_BITS; j++) begin : g_step
        logic [DATA_W-1:0] rin, rout;
        if (j == 0) begin : g_first
            assign rin = rem_q;
        end else begin : g_next
            assign rin = g_step[j-1].rout;
        end
        mdu_div_step #(.W(DATA_W)) u_step (
            .rem_i (rin),
            .dvs_i (dvs_q),
            .bit_i (quo_q[DATA_W-1-j]),
            .rem_o (rout),
            .q_o   (qbits[DIV_RADIX_BITS-1-j])
        );
    end
    assign rem_nxt = g_step[DIV_RADIX_BITS-1].rout;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (op_valid && !kill) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state_d = S_MUL;
                                cnt_d   = CW'(MUL_LAT - 1);
                                a_d     = src1;
                                b_d     = src2;
                                sgn_d   = sd;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_d = S_DIV;
                                cnt_d   = CW'(N - 1);
                                a_d     = src1;
                                b_d     = src2;
                                dvs_d   = b_mag;
                                quo_d   = a_mag;
                                rem_d   = '0;
                                negq_d  = sd & (src1[DATA_W-1] ^ src2[DATA_W-1]);
                                negr_d  = sd & src1[DATA_W-1];
                            end
                            OP_MTHI: hi_d = src1;
                            OP_MTLO: lo_d = src1;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = prod;
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DIV: begin
                    rem_d = rem_nxt;
                    quo_d = {quo_q[DATA_W-DIV_RADIX_BITS-1:0], qbits};
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    if (b_q == '0) begin
                        lo_d = {DATA_W{DZ_LO_BIT}};
                        hi_d = DZ_HI_IS_SRC1 ? a_q : rem_q;
                    end else begin
                        lo_d = negq_q ? -quo_q : quo_q;
                        hi_d = negr_q ? -rem_q : rem_q;
                    end
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
